// File: rtl/regfile_port_ctrl_if.sv
// regfile_port_ctrl_if
//   Bundles every non-clock signal of regfile_port_ctrl: the operand-fetch
//   request, the operand response, the writeback port and the register-bank
//   slice selects/data.
//   master : controller view (drives readies, selects, operands, write strobe)
//   slave  : pipeline + register bank view
//
//   req_valid/req_ready/req_rs/req_rt        operand-fetch request
//   rf_rs/rf_rt, rf_a_data/rf_b_data         bank read selects and read data
//   opnd_valid/opnd_ready/opnd_a/opnd_b      operand response
//   wb_valid/wb_ready/wb_rd/wb_data          writeback request
//   rf_rd/rf_wdata/rf_we                     bank write select, data, strobe
interface regfile_port_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_rs;
  logic [AW-1:0] req_rt;

  logic [AW-1:0] rf_rs;
  logic [AW-1:0] rf_rt;
  logic [DW-1:0] rf_a_data;
  logic [DW-1:0] rf_b_data;

  logic          opnd_valid;
  logic          opnd_ready;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;

  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic          rf_we;

  modport master (
    input  req_valid, req_rs, req_rt,
    input  rf_a_data, rf_b_data,
    input  opnd_ready,
    input  wb_valid, wb_rd, wb_data,
    output req_ready,
    output rf_rs, rf_rt,
    output opnd_valid, opnd_a, opnd_b,
    output wb_ready,
    output rf_rd, rf_wdata, rf_we
  );

  modport slave (
    output req_valid, req_rs, req_rt,
    output rf_a_data, rf_b_data,
    output opnd_ready,
    output wb_valid, wb_rd, wb_data,
    input  req_ready,
    input  rf_rs, rf_rt,
    input  opnd_valid, opnd_a, opnd_b,
    input  wb_ready,
    input  rf_rd, rf_wdata, rf_we
  );
endinterface

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl
//   Initiator side of the per-register slice interface. Accepts an operand
//   fetch (rs, rt), drives the bank read selects for RD_LAT cycles, captures
//   both operands and holds them until the consumer takes them. A separate
//   writeback port registers one bank write per accepted writeback and
//   forwards writebacks that land while a read is in flight. R0 reads as
//   zero and is never written.
//
//   Parameters: RD_LAT (1..7) select-to-sample latency, DW data width,
//               AW register address width.
//   Ports:      clk  rising-edge clock
//               rst  synchronous active-high reset
//               bus  regfile_port_ctrl_if.master (request, operand,
//                    writeback and bank signals)

// One read path (A or B): owns its select register, its forward flag and
// forwarded value, and its operand register.
//   start      request accepted this cycle: latch select, clear forward
//   in_read    controller is in a READ cycle (forward window)
//   capture    last READ cycle: load the operand register
module regfile_port_ctrl_lane #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_read,
  input  logic          capture,
  input  logic [AW-1:0] req_sel,
  input  logic          wb_fire,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic [DW-1:0] bank_data,
  output logic [AW-1:0] rf_sel,
  output logic [DW-1:0] opnd
);
  logic          fwd;
  logic [DW-1:0] fwd_data;
  logic          hit;
  logic [DW-1:0] cap_val;

  // A writeback to R0 never forwards; R0 is hard zero below anyway.
  assign hit = wb_fire && (wb_rd != '0) && (wb_rd == rf_sel);

  // A hit in the capture cycle itself has not reached fwd_data yet, so it
  // takes priority over the stored forward value.
  always_comb begin
    cap_val = bank_data;
    if (rf_sel == '0)   cap_val = '0;
    else if (hit)       cap_val = wb_data;
    else if (fwd)       cap_val = fwd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_sel   <= '0;
      fwd      <= 1'b0;
      fwd_data <= '0;
      opnd     <= '0;
    end else begin
      if (start) begin
        rf_sel <= req_sel;
        fwd    <= 1'b0;
      end else if (in_read && hit) begin
        fwd      <= 1'b1;
        fwd_data <= wb_data;
      end
      if (capture) opnd <= cap_val;
    end
  end
endmodule

module regfile_port_ctrl #(
  parameter int RD_LAT = 1,
  parameter int DW     = 32,
  parameter int AW     = 5
) (
  input logic                 clk,
  input logic                 rst,
  regfile_port_ctrl_if.master bus
);
  localparam int NUM_LANES = 2;   // lane 0 = A (rs), lane 1 = B (rt)
  localparam int CW        = 3;   // counter covers RD_LAT up to 7
  localparam logic [CW-1:0] LAT = CW'(RD_LAT);
  localparam logic [CW-1:0] ONE = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          req_ready_q;
  logic          opnd_valid_q;
  logic          wb_ready_q;
  logic          rf_we_q;
  logic [AW-1:0] rf_rd_q;
  logic [DW-1:0] rf_wdata_q;

  logic req_fire;
  logic wb_fire;
  logic in_read;
  logic capture;

  logic [NUM_LANES-1:0][AW-1:0] req_sel;
  logic [NUM_LANES-1:0][AW-1:0] rf_sel;
  logic [NUM_LANES-1:0][DW-1:0] bank_data;
  logic [NUM_LANES-1:0][DW-1:0] opnd;

  assign req_fire = bus.req_valid & req_ready_q;
  assign wb_fire  = bus.wb_valid & wb_ready_q;
  assign in_read  = (state == READ);
  assign capture  = in_read && (cnt == ONE);

  assign req_sel   = {bus.req_rt, bus.req_rs};
  assign bank_data = {bus.rf_b_data, bus.rf_a_data};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    regfile_port_ctrl_lane #(
      .DW (DW),
      .AW (AW)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .start     (req_fire),
      .in_read   (in_read),
      .capture   (capture),
      .req_sel   (req_sel[l]),
      .wb_fire   (wb_fire),
      .wb_rd     (bus.wb_rd),
      .wb_data   (bus.wb_data),
      .bank_data (bank_data[l]),
      .rf_sel    (rf_sel[l]),
      .opnd      (opnd[l])
    );
  end

  // Control FSM. req_ready is registered so that it is low during the reset
  // cycle and the cycle right after it, and rises once IDLE is settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_q  <= 1'b0;
      opnd_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            state       <= READ;
            cnt         <= LAT;
            req_ready_q <= 1'b0;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        READ: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            state        <= HOLD;
            opnd_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          // req_ready is still low here, so no request can fire alongside
          // the operand handshake.
          if (bus.opnd_ready) begin
            state        <= IDLE;
            opnd_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          req_ready_q  <= 1'b0;
          opnd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Writeback register: one strobe cycle per accepted writeback; select and
  // data stay put afterwards. R0 writes are registered but never strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ready_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      wb_ready_q <= 1'b1;
      rf_we_q    <= wb_fire && (bus.wb_rd != '0);
      if (wb_fire) begin
        rf_rd_q    <= bus.wb_rd;
        rf_wdata_q <= bus.wb_data;
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.opnd_valid = opnd_valid_q;
  assign bus.wb_ready   = wb_ready_q;
  assign bus.rf_rs      = rf_sel[0];
  assign bus.rf_rt      = rf_sel[1];
  assign bus.opnd_a     = opnd[0];
  assign bus.opnd_b     = opnd[1];
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_we      = rf_we_q;
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// tb_regfile_port_ctrl
//   Two instances: RD_LAT=1 for the basic-fetch timing case, RD_LAT=3 for
//   everything else. The RD_LAT=3 instance sits on a behavioural register
//   bank and is tracked every cycle by an architectural model: a golden
//   register array updated on each accepted writeback, with each fetch
//   expected to return the golden value of its registers as of its capture
//   cycle.
module tb_regfile_port_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LAT = 3;

  logic clk;
  logic rst;

  regfile_port_ctrl_if #(.DW(DW), .AW(AW)) b1 ();
  regfile_port_ctrl_if #(.DW(DW), .AW(AW)) b3 ();

  regfile_port_ctrl #(.RD_LAT(1), .DW(DW), .AW(AW)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  regfile_port_ctrl #(.RD_LAT(LAT), .DW(DW), .AW(AW)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- RD_LAT=1 bank: fixed data ----------------
  assign b1.rf_a_data = 32'h1111_1111;
  assign b1.rf_b_data = 32'h2222_2222;

  // ---------------- RD_LAT=3 bank ----------------
  logic [DW-1:0] bank [32];
  logic          bank_init = 1'b0;
  logic          ovr_en;   // force bank reads to a stale zero

  always @(posedge clk) begin
    if (!bank_init) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
      bank[0]   <= 32'hFFFF_FFFF;   // R0 slice returns junk; must be masked
      bank_init <= 1'b1;
    end else if (b3.rf_we === 1'b1) begin
      bank[b3.rf_rd] <= b3.rf_wdata;
    end
  end

  always_comb begin
    b3.rf_a_data = ovr_en ? '0 : bank[b3.rf_rs];
    b3.rf_b_data = ovr_en ? '0 : bank[b3.rf_rt];
  end

  // ---------------- architectural model for RD_LAT=3 ----------------
  logic [DW-1:0] golden [32];
  logic          mon_on = 1'b0;
  int            cyc    = 0;
  int            cap_at = 0;
  logic          busy, m_rdy, m_wbr, m_vld, m_we;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [DW-1:0] m_a, m_b, m_wd;

  initial for (int i = 0; i < 32; i++) golden[i] = '0;

  always @(negedge clk) begin
    logic wbf, rqf;
    if (mon_on) begin
      chk("req_ready",  b3.req_ready,  m_rdy);
      chk("wb_ready",   b3.wb_ready,   m_wbr);
      chk("opnd_valid", b3.opnd_valid, m_vld);
      chk("opnd_a",     b3.opnd_a,     m_a);
      chk("opnd_b",     b3.opnd_b,     m_b);
      chk("rf_rs",      b3.rf_rs,      m_rs);
      chk("rf_rt",      b3.rf_rt,      m_rt);
      chk("rf_we",      b3.rf_we,      m_we);
      chk("rf_rd",      b3.rf_rd,      m_rd);
      chk("rf_wdata",   b3.rf_wdata,   m_wd);
    end
    if (rst) begin
      mon_on = 1'b1;
      busy = 0; m_rdy = 0; m_wbr = 0; m_vld = 0; m_we = 0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_a = '0; m_b = '0; m_wd = '0;
    end else if (mon_on) begin
      wbf  = b3.wb_valid && m_wbr;
      rqf  = b3.req_valid && m_rdy;
      m_we = wbf && (b3.wb_rd != 0);
      if (wbf) begin
        m_rd = b3.wb_rd;
        m_wd = b3.wb_data;
        if (b3.wb_rd != 0) golden[b3.wb_rd] = b3.wb_data;
      end
      if (busy && cyc == cap_at) begin
        m_a   = (m_rs == 0) ? '0 : golden[m_rs];
        m_b   = (m_rt == 0) ? '0 : golden[m_rt];
        m_vld = 1'b1;
        busy  = 1'b0;
      end else if (m_vld && b3.opnd_ready) begin
        m_vld = 1'b0;
        m_rdy = 1'b1;
      end else if (rqf) begin
        busy   = 1'b1;
        cap_at = cyc + LAT;
        m_rs   = b3.req_rs;
        m_rt   = b3.req_rt;
        m_rdy  = 1'b0;
      end else if (!busy && !m_vld) begin
        m_rdy = 1'b1;
      end
      m_wbr = 1'b1;
    end
    cyc++;
  end

  task automatic wait_rdy3();
    int n = 0;
    while (b3.req_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("req_ready_wait", b3.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ovr_en = 1'b0;
    b1.req_valid = 0; b1.req_rs = '0; b1.req_rt = '0; b1.opnd_ready = 0;
    b1.wb_valid = 0;  b1.wb_rd = '0;  b1.wb_data = '0;
    b3.req_valid = 0; b3.req_rs = '0; b3.req_rt = '0; b3.opnd_ready = 0;
    b3.wb_valid = 0;  b3.wb_rd = '0;  b3.wb_data = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_rdy1",   b1.req_ready,  0);
    chk("rst_vld1",   b1.opnd_valid, 0);
    chk("rst_wbr1",   b1.wb_ready,   0);
    chk("rst_rs1",    b1.rf_rs,      0);
    chk("rst_opa1",   b1.opnd_a,     0);
    step();
    rst = 1'b0;
    step();

    // ---- basic fetch, RD_LAT=1 ----
    b1.req_valid = 1; b1.req_rs = 5'd3; b1.req_rt = 5'd4;
    @(negedge clk);
    chk("b_rdy_c0", b1.req_ready, 1);
    step();
    b1.req_valid = 0;
    @(negedge clk);
    chk("b_rs_c1",  b1.rf_rs, 3);
    chk("b_rt_c1",  b1.rf_rt, 4);
    chk("b_rdy_c1", b1.req_ready, 0);
    chk("b_vld_c1", b1.opnd_valid, 0);
    step();
    b1.opnd_ready = 1;
    @(negedge clk);
    chk("b_vld_c2", b1.opnd_valid, 1);
    chk("b_a_c2",   b1.opnd_a, 32'h1111_1111);
    chk("b_b_c2",   b1.opnd_b, 32'h2222_2222);
    chk("b_rdy_c2", b1.req_ready, 0);
    step();
    b1.opnd_ready = 0;
    @(negedge clk);
    chk("b_vld_c3", b1.opnd_valid, 0);
    chk("b_rdy_c3", b1.req_ready, 1);

    // ---- R0 read and R0 write suppression ----
    wait_rdy3();
    b3.req_valid = 1; b3.req_rs = '0; b3.req_rt = '0;
    b3.wb_valid = 1;  b3.wb_rd = '0;  b3.wb_data = 32'h5;
    step();
    b3.req_valid = 0; b3.wb_valid = 0;
    @(negedge clk);
    chk("r0_we", b3.rf_we, 0);
    repeat (3) step();
    @(negedge clk);
    chk("r0_vld", b3.opnd_valid, 1);
    chk("r0_a",   b3.opnd_a, 0);
    chk("r0_b",   b3.opnd_b, 0);
    b3.opnd_ready = 1;
    step();
    b3.opnd_ready = 0;

    // ---- forward during READ, then HOLD backpressure ----
    wait_rdy3();
    ovr_en = 1'b1;
    b3.req_valid = 1; b3.req_rs = 5'd7; b3.req_rt = 5'd7;
    step();
    b3.req_valid = 0;
    b3.wb_valid = 1; b3.wb_rd = 5'd7; b3.wb_data = 32'hA;
    step();
    b3.wb_data = 32'hB;
    step();
    b3.wb_valid = 0;
    step();
    ovr_en = 1'b0;
    @(negedge clk);
    chk("fwd_vld", b3.opnd_valid, 1);
    chk("fwd_a",   b3.opnd_a, 32'hB);
    chk("fwd_b",   b3.opnd_b, 32'hB);
    for (int i = 0; i < 5; i++) begin
      step();
      b3.wb_valid = (i == 1); b3.wb_rd = 5'd7; b3.wb_data = 32'hC;
      @(negedge clk);
      chk("hold_a",   b3.opnd_a, 32'hB);
      chk("hold_vld", b3.opnd_valid, 1);
    end
    step();
    b3.wb_valid = 0; b3.opnd_ready = 1;
    @(negedge clk);
    chk("hs_vld", b3.opnd_valid, 1);
    step();
    b3.opnd_ready = 0;
    @(negedge clk);
    chk("rel_vld", b3.opnd_valid, 0);
    chk("rel_rdy", b3.req_ready, 1);

    // ---- back-to-back writeback timing ----
    step();
    b3.wb_valid = 1; b3.wb_rd = 5'd9; b3.wb_data = 32'h1234;
    step();
    b3.wb_rd = 5'd10; b3.wb_data = 32'h5678;
    @(negedge clk);
    chk("wb1_we", b3.rf_we, 1);
    chk("wb1_rd", b3.rf_rd, 9);
    chk("wb1_wd", b3.rf_wdata, 32'h1234);
    step();
    b3.wb_valid = 0;
    @(negedge clk);
    chk("wb2_we", b3.rf_we, 1);
    chk("wb2_rd", b3.rf_rd, 10);
    chk("wb2_wd", b3.rf_wdata, 32'h5678);
    step();
    @(negedge clk);
    chk("wb3_we", b3.rf_we, 0);
    chk("wb3_rd", b3.rf_rd, 10);

    // ---- reset in the second READ cycle, with a writeback ----
    wait_rdy3();
    b3.req_valid = 1; b3.req_rs = 5'd1; b3.req_rt = 5'd2;
    step();
    b3.req_valid = 0;
    step();
    rst = 1'b1;
    b3.wb_valid = 1; b3.wb_rd = 5'd5; b3.wb_data = 32'h77;
    step();
    rst = 1'b0;
    b3.wb_valid = 0;
    @(negedge clk);
    chk("mr_vld", b3.opnd_valid, 0);
    chk("mr_rdy", b3.req_ready, 0);
    chk("mr_we",  b3.rf_we, 0);
    chk("mr_wbr", b3.wb_ready, 0);
    chk("mr_a",   b3.opnd_a, 0);
    chk("mr_b",   b3.opnd_b, 0);
    chk("mr_rs",  b3.rf_rs, 0);
    chk("mr_rt",  b3.rf_rt, 0);
    chk("mr_rd",  b3.rf_rd, 0);
    chk("mr_wd",  b3.rf_wdata, 0);
    step();
    @(negedge clk);
    chk("mr_rdy_up", b3.req_ready, 1);
    chk("mr_wbr_up", b3.wb_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("mr_no_stale", b3.opnd_valid, 0);
    end

    // ---- randomized traffic, checked by the model every cycle ----
    for (int i = 0; i < 800; i++) begin
      step();
      rst           = ($urandom_range(0, 299) == 0);
      b3.req_valid  = 1'($urandom_range(0, 1));
      b3.req_rs     = AW'($urandom_range(0, 7));
      b3.req_rt     = AW'($urandom_range(0, 7));
      b3.wb_valid   = ($urandom_range(0, 9) < 4);
      b3.wb_rd      = AW'($urandom_range(0, 7));
      b3.wb_data    = $urandom;
      b3.opnd_ready = 1'($urandom_range(0, 1));
    end
    step();
    rst = 1'b0;
    b3.req_valid = 0; b3.wb_valid = 0; b3.opnd_ready = 1;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
